alu_operand_sequencer: RTL
==========================

Name: alu_operand_sequencer

Overview:
- Datapath stage that sits around the 16-bit ALU (Ain, Bin, ALUop -> out, Z).
- Holds an 8 x 16-bit register file and fetches two operands over a single read port.
- Optionally shifts operand B, presents registered operands and opcode to the ALU, then captures the result and zero flag and writes the result back.
- Sequencing is a small FSM with a start/busy/done handshake.

Parameters:
- WIDTH, 16, datapath width; ALU width must match.
- NREGS, 8, register file depth; register index width is log2(NREGS) = 3.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- rn_a  input  3  source register for Ain.
- rn_b  input  3  source register for Bin (pre-shift).
- rn_d  input  3  destination register.
- shift  input  2  B shift: 00 none, 01 left 1 (fill 0), 10 logical right 1, 11 arithmetic right 1.
- op  input  2  ALU opcode forwarded to ALUop: 00 add, 01 sub, 10 and, 11 not-B.
- ext_we  input  1  external register write, honoured only in IDLE.
- ext_num  input  3  external write index.
- ext_data  input  WIDTH  external write data.
- dbg_num  input  3  debug read index.
- dbg_data  output  WIDTH  combinational read of regfile[dbg_num].
- Ain  output  WIDTH  registered operand A to ALU.
- Bin  output  WIDTH  registered shifted operand B to ALU.
- ALUop  output  2  registered opcode to ALU.
- alu_out  input  WIDTH  ALU result.
- alu_z  input  1  ALU zero flag.
- status_z  output  1  registered Z of last completed operation.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse in WRITE.

Behaviour:
- Reset (async, reset_n=0): all 8 registers = 0; state = IDLE; Ain, Bin = 0; ALUop = 00; status_z = 0; busy = 0; done = 0; internal C = 0.
- Register-then-compute-then-writeback stage; the ALU is external and combinational.

FSM states: IDLE -> READ_A -> READ_B -> EXEC -> WRITE -> IDLE.
- IDLE: if start = 1, latch rn_a/rn_b/rn_d/shift/op into command regs and go to READ_A; otherwise stay.
- READ_A: Ain <= regfile[rn_a].
- READ_B: Bin <= shift(regfile[rn_b]); ALUop <= op.
- EXEC: C <= alu_out; status_z <= alu_z.
- WRITE: regfile[rn_d] <= C; done = 1. Next state is IDLE.

Timing and handshake:
- Latency: start sampled at edge N; done high in cycle N+4; the result is visible on dbg_data from cycle N+5.
- start while busy is ignored; no queueing.
- A back-to-back start is legal in the cycle after WRITE, i.e. the IDLE cycle.
- Commands are latched at acceptance; later input changes do not affect an operation in flight.

External writes:
- ext_we in IDLE writes regfile[ext_num] <= ext_data at that edge.
- If ext_we and start occur in the same IDLE cycle, both take effect. The external write lands first, so READ_A/READ_B see the new value.
- ext_we while busy is dropped.

Operand and arithmetic rules:
- rn_a = rn_b is legal; both reads return the same register.
- rn_d may equal a source register; the write occurs only in WRITE.
- All arithmetic is modulo 2^WIDTH.
- Shift: arithmetic right replicates bit WIDTH-1; left shift drops bit WIDTH-1.
- Ain, Bin and ALUop hold their values between operations.

Reset mid-operation:
- Any state returns to IDLE immediately.
- No writeback occurs and the register file is cleared.

Decomposition:
- Shared package: state encoding (IDLE, READ_A, READ_B, EXEC, WRITE), shift codes (SH_NONE, SH_LSL, SH_LSR, SH_ASR), ALU op codes (OP_ADD, OP_SUB, OP_AND, OP_NOTB), WIDTH and NREGS constants.
- One natural sub-module: operand_shifter (combinational WIDTH-bit, 2-bit shift select), reusable elsewhere in the datapath.
- Register file and FSM stay in the top.

Test Plan:
(Bench instantiates the existing ALU connected to Ain/Bin/ALUop/alu_out/alu_z.)
- ext write R1=0x0449, R2=0x0213; start rn_a=1 rn_b=2 rn_d=3 op=00 shift=00 -> done at start+4; dbg R3=0x065C; status_z=0.
- op=01 same sources, rn_d=4 -> R4=0x0236. Then shift=01, op=00, rn_d=5 -> Bin=0x0426, R5=0x086F.
- R6=0x8004; op=11, shift=11, rn_b=6, rn_d=7 -> Bin=0xC002, R7=0x3FFD. Same with shift=10 -> Bin=0x4002, R7=0xBFFD.
- R1-R1 (op=01, rn_a=rn_b=1, rn_d=0) -> R0=0x0000, status_z=1. A following nonzero add -> status_z=0.
- start held high through an operation, plus ext_we to R2 while busy -> exactly one operation and R2 unchanged. Simultaneous ext_we R2=0x0001 with start (rn_b=2) -> operation uses 0x0001.
- reset_n pulsed low during EXEC of an op targeting R3 -> busy=0 and done=0 immediately; R3=0 (no writeback); all outputs at reset values.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM states,
// B-operand shift codes, ALU opcodes and default datapath sizes.
package alu_operand_sequencer_pkg;

  localparam int SEQ_WIDTH = 16;
  localparam int SEQ_NREGS = 8;
  localparam int SEQ_IDX_W = $clog2(SEQ_NREGS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_AND  = 2'b10,
    OP_NOTB = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_operand_sequencer_operand_shifter.sv
// Combinational single-bit shifter for the B operand: pass, shift left,
// logical shift right or arithmetic shift right.
module operand_shifter
  import alu_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    case (shift_e'(sel_i))
      SH_LSL:  dout_o = {din_i[WIDTH-2:0], 1'b0};
      SH_LSR:  dout_o = {1'b0, din_i[WIDTH-1:1]};
      SH_ASR:  dout_o = {din_i[WIDTH-1], din_i[WIDTH-1:1]};
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Register file plus sequencing FSM that fetches two operands over one read
// port, feeds an external combinational ALU and writes the result back.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int NREGS = SEQ_NREGS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [$clog2(NREGS)-1:0] rn_a,
  input  logic [$clog2(NREGS)-1:0] rn_b,
  input  logic [$clog2(NREGS)-1:0] rn_d,
  input  logic [1:0]               shift,
  input  logic [1:0]               op,
  input  logic                     ext_we,
  input  logic [$clog2(NREGS)-1:0] ext_num,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic [$clog2(NREGS)-1:0] dbg_num,
  output logic [WIDTH-1:0]         dbg_data,
  output logic [WIDTH-1:0]         Ain,
  output logic [WIDTH-1:0]         Bin,
  output logic [1:0]               ALUop,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_z,
  output logic                     status_z,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = $clog2(NREGS);

  state_e             state_q;
  logic [IDX_W-1:0]   rn_a_q, rn_b_q, rn_d_q;
  logic [1:0]         shift_q, op_q;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   ain_q, bin_q, c_q;
  logic [1:0]         aluop_q;
  logic               status_z_q, done_q;
  logic [WIDTH-1:0]   shifted_b;

  operand_shifter #(.WIDTH(WIDTH)) u_shifter (
    .din_i  (regs_q[rn_b_q]),
    .sel_i  (shift_q),
    .dout_o (shifted_b)
  );

  // Commands are captured on acceptance so the operation ignores later input changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rn_a_q     <= '0;
      rn_b_q     <= '0;
      rn_d_q     <= '0;
      shift_q    <= '0;
      op_q       <= '0;
      ain_q      <= '0;
      bin_q      <= '0;
      aluop_q    <= '0;
      c_q        <= '0;
      status_z_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // External write lands at this edge, so READ_A/READ_B see it.
          if (ext_we) regs_q[ext_num] <= ext_data;
          if (start) begin
            rn_a_q  <= rn_a;
            rn_b_q  <= rn_b;
            rn_d_q  <= rn_d;
            shift_q <= shift;
            op_q    <= op;
            state_q <= READ_A;
          end
        end
        READ_A: begin
          ain_q   <= regs_q[rn_a_q];
          state_q <= READ_B;
        end
        READ_B: begin
          bin_q   <= shifted_b;
          aluop_q <= op_q;
          state_q <= EXEC;
        end
        EXEC: begin
          c_q        <= alu_out;
          status_z_q <= alu_z;
          done_q     <= 1'b1;
          state_q    <= WRITE;
        end
        WRITE: begin
          regs_q[rn_d_q] <= c_q;
          done_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign Ain      = ain_q;
  assign Bin      = bin_q;
  assign ALUop    = aluop_q;
  assign status_z = status_z_q;
  assign dbg_data = regs_q[dbg_num];

endmodule
